// File: rtl/cache_req_buf_pkg.sv
// Shared types and widths for the cache request buffer.
// Early fields are known at issue time, late fields come back from the MMU.
package cache_pkg;

   localparam int CACHE_ADDR_W = 32;
   localparam int CACHE_OP_W   = 32;

   typedef struct packed {
      logic [CACHE_ADDR_W-1:0] addr;
      logic [CACHE_OP_W-1:0]   opcode;
      logic                    opflag;
   } req_early_t;

   typedef struct packed {
      logic [CACHE_ADDR_W-1:0] paddr;
      logic                    suc;
   } req_late_t;

endpackage

// File: rtl/cache_req_buf_if.sv
// Handshake bundle between stage 1, the MMU, the request buffer and stage 2.
// Both sides of the buffer use valid/ready: a beat transfers on a cycle where
// valid and ready are both high; valid must not depend on ready, and the
// buffer's in_ready depends on registered state only. The MMU fields carry no
// handshake: they are sampled in the single cycle the buffer expects them.
interface cache_req_buf_if #(
   parameter int ADDR_W = cache_pkg::CACHE_ADDR_W,
   parameter int OP_W   = cache_pkg::CACHE_OP_W
);
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_addr;
   logic [OP_W-1:0]   in_opcode;
   logic              in_opflag;
   logic [ADDR_W-1:0] mmu_paddr;
   logic              mmu_suc;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [OP_W-1:0]   out_opcode;
   logic              out_opflag;
   logic [ADDR_W-1:0] out_paddr;
   logic              out_suc;

   // Requester / MMU / consumer side.
   modport master (
      output in_valid, in_addr, in_opcode, in_opflag, mmu_paddr, mmu_suc, out_ready,
      input  in_ready, out_valid, out_addr, out_opcode, out_opflag, out_paddr, out_suc
   );

   // Buffer side.
   modport slave (
      input  in_valid, in_addr, in_opcode, in_opflag, mmu_paddr, mmu_suc, out_ready,
      output in_ready, out_valid, out_addr, out_opcode, out_opflag, out_paddr, out_suc
   );
endinterface

// File: rtl/cache_req_buf_delay_pipe.sv
// Shift register of {vld, idx} tracking which entry the MMU answers for.
// The last stage marks the cycle in which mmu_paddr/mmu_suc belong to entry idx.
module cache_req_delay_pipe #(
   parameter int LAT   = 1,
   parameter int IDX_W = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             in_vld,
   input  logic [IDX_W-1:0] in_idx,
   output logic             out_vld,
   output logic [IDX_W-1:0] out_idx
);

   logic [LAT-1:0]   vld_q;
   logic [IDX_W-1:0] idx_q [LAT];

   // Shift the slots forward every cycle; reset or flush empties the whole pipe.
   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         vld_q <= '0;
         for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
      end else begin
         vld_q[0] <= in_vld;
         idx_q[0] <= in_idx;
         for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            idx_q[i] <= idx_q[i-1];
         end
      end
   end

   assign out_vld = vld_q[LAT-1];
   assign out_idx = idx_q[LAT-1];

endmodule

// File: rtl/cache_req_buf.sv
// Request buffer between cache stage 1 and stage 2. Early fields are captured
// at enqueue; paddr/SUC arrive MMU_LAT cycles later and are forwarded to the
// head combinationally in the cycle they are written.
module cache_req_buf
   import cache_pkg::*;
#(
   parameter int ADDR_W  = CACHE_ADDR_W,
   parameter int OP_W    = CACHE_OP_W,
   parameter int DEPTH   = 2,
   parameter int MMU_LAT = 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   flush,
   cache_req_buf_if.slave         bus,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   req_early_t       early_q [DEPTH];
   req_late_t        late_q  [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] late_valid_q;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count_q;

   logic             push;
   logic             pop;
   logic             pipe_vld;
   logic [PTR_W-1:0] pipe_idx;
   logic             late_hit;
   logic             late_wr;

   assign bus.in_ready = (count_q != CNT_W'(DEPTH));
   assign push         = bus.in_valid & bus.in_ready & ~flush;
   assign late_hit     = pipe_vld & (pipe_idx == rd_ptr);
   assign bus.out_valid = valid_q[rd_ptr] & (late_valid_q[rd_ptr] | late_hit);
   assign pop          = bus.out_valid & bus.out_ready;
   // A late write aimed at the entry being popped is dropped with the entry.
   assign late_wr      = pipe_vld & ~(pop & (pipe_idx == rd_ptr));

   assign bus.out_addr   = ADDR_W'(early_q[rd_ptr].addr);
   assign bus.out_opcode = OP_W'(early_q[rd_ptr].opcode);
   assign bus.out_opflag = early_q[rd_ptr].opflag;
   assign bus.out_paddr  = late_hit ? bus.mmu_paddr : ADDR_W'(late_q[rd_ptr].paddr);
   assign bus.out_suc    = late_hit ? bus.mmu_suc   : late_q[rd_ptr].suc;
   assign count          = count_q;

   cache_req_delay_pipe #(
      .LAT   (MMU_LAT),
      .IDX_W (PTR_W)
   ) u_pipe (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (flush),
      .in_vld  (push),
      .in_idx  (wr_ptr),
      .out_vld (pipe_vld),
      .out_idx (pipe_idx)
   );

   // Entry storage, pointers and occupancy; flush drops bookkeeping but keeps data.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count_q      <= '0;
         valid_q      <= '0;
         late_valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            early_q[i] <= '0;
            late_q[i]  <= '0;
         end
      end else if (flush) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count_q      <= '0;
         valid_q      <= '0;
         late_valid_q <= '0;
      end else begin
         if (push) begin
            early_q[wr_ptr].addr   <= bus.in_addr[CACHE_ADDR_W-1:0];
            early_q[wr_ptr].opcode <= bus.in_opcode[CACHE_OP_W-1:0];
            early_q[wr_ptr].opflag <= bus.in_opflag;
            valid_q[wr_ptr]        <= 1'b1;
            late_valid_q[wr_ptr]   <= 1'b0;
            wr_ptr                 <= wr_ptr + PTR_W'(1);
         end
         if (late_wr) begin
            late_q[pipe_idx].paddr <= bus.mmu_paddr[CACHE_ADDR_W-1:0];
            late_q[pipe_idx].suc   <= bus.mmu_suc;
            late_valid_q[pipe_idx] <= 1'b1;
         end
         if (pop) begin
            valid_q[rd_ptr]      <= 1'b0;
            late_valid_q[rd_ptr] <= 1'b0;
            rd_ptr               <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_req_buf.sv
// Bench for cache_req_buf: one instance with DEPTH=2/MMU_LAT=1 and one with
// DEPTH=4/MMU_LAT=3, selected by sel. Directed scenarios plus a random stream
// checked against a queue model of in-order requests and their MMU answers.
module tb_cache_req_buf;

   logic        clk = 1'b0;
   logic        rstn;
   logic        flush;
   logic        sel;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_addr;
   logic [31:0] in_opcode;
   logic        in_opflag;
   logic [31:0] mmu_paddr;
   logic        mmu_suc;

   logic        o_valid;
   logic        o_ready;
   logic [31:0] o_addr;
   logic [31:0] o_op;
   logic        o_flag;
   logic [31:0] o_paddr;
   logic        o_suc;
   logic [2:0]  o_count;
   logic [1:0]  count_a;
   logic [2:0]  count_b;

   int n_tests = 0;
   int n_fail  = 0;

   // expected entry: {addr, opcode, opflag, paddr, suc}
   logic [97:0] exp_q[$];
   int          cyc_q[$];

   cache_req_buf_if #(.ADDR_W(32), .OP_W(32)) ifa ();
   cache_req_buf_if #(.ADDR_W(32), .OP_W(32)) ifb ();

   cache_req_buf #(.ADDR_W(32), .OP_W(32), .DEPTH(2), .MMU_LAT(1)) u_dut_a (
      .clk   (clk),
      .rstn  (rstn),
      .flush (flush),
      .bus   (ifa),
      .count (count_a)
   );

   cache_req_buf #(.ADDR_W(32), .OP_W(32), .DEPTH(4), .MMU_LAT(3)) u_dut_b (
      .clk   (clk),
      .rstn  (rstn),
      .flush (flush),
      .bus   (ifb),
      .count (count_b)
   );

   // clock
   always #5 clk = ~clk;

   assign ifa.in_valid  = in_valid & ~sel;
   assign ifa.out_ready = out_ready & ~sel;
   assign ifa.in_addr   = in_addr;
   assign ifa.in_opcode = in_opcode;
   assign ifa.in_opflag = in_opflag;
   assign ifa.mmu_paddr = mmu_paddr;
   assign ifa.mmu_suc   = mmu_suc;
   assign ifb.in_valid  = in_valid & sel;
   assign ifb.out_ready = out_ready & sel;
   assign ifb.in_addr   = in_addr;
   assign ifb.in_opcode = in_opcode;
   assign ifb.in_opflag = in_opflag;
   assign ifb.mmu_paddr = mmu_paddr;
   assign ifb.mmu_suc   = mmu_suc;

   assign o_valid = sel ? ifb.out_valid  : ifa.out_valid;
   assign o_ready = sel ? ifb.in_ready   : ifa.in_ready;
   assign o_addr  = sel ? ifb.out_addr   : ifa.out_addr;
   assign o_op    = sel ? ifb.out_opcode : ifa.out_opcode;
   assign o_flag  = sel ? ifb.out_opflag : ifa.out_opflag;
   assign o_paddr = sel ? ifb.out_paddr  : ifa.out_paddr;
   assign o_suc   = sel ? ifb.out_suc    : ifa.out_suc;
   assign o_count = sel ? count_b : {1'b0, count_a};

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drive_idle();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_addr   = $urandom;
      in_opcode = $urandom;
      in_opflag = 1'($urandom_range(0, 1));
      mmu_paddr = $urandom;
      mmu_suc   = 1'($urandom_range(0, 1));
   endtask

   task automatic drive_push(input logic [31:0] a, input logic [31:0] op, input logic fl);
      in_valid  = 1'b1;
      in_addr   = a;
      in_opcode = op;
      in_opflag = fl;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      sel  = 1'b0;
      rstn = 1'b0;
      drive_idle();
      tick();
      tick();
      rstn = 1'b1;
      sample();
      n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", o_valid); end
      n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", o_ready); end
      n_tests++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", o_count); end
      n_tests++; if ({o_addr, o_op, o_flag} !== 65'd0) begin n_fail++; $display("FAIL reset_early got %0h/%0h/%0b want 0", o_addr, o_op, o_flag); end
      n_tests++; if ({o_paddr, o_suc} !== 33'd0) begin n_fail++; $display("FAIL reset_late got %0h/%0b want 0", o_paddr, o_suc); end
      sel = 1'b1;
      sample();
      n_tests++; if ({o_valid, o_ready, o_count} !== 5'b01000) begin n_fail++; $display("FAIL reset_b_status got %0b want 01000", {o_valid, o_ready, o_count}); end
      sel = 1'b0;
      tick();
   endtask

   task automatic test_bypass();
      sel = 1'b0;
      drive_idle();
      drive_push(32'h1000, 32'hA5, 1'b1);
      sample();
      n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL byp_t0_valid got %0b want 0", o_valid); end
      tick();
      drive_idle();
      mmu_paddr = 32'h8000_1000;
      mmu_suc   = 1'b1;
      out_ready = 1'b1;
      sample();
      n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL byp_t1_valid got %0b want 1", o_valid); end
      n_tests++; if (o_paddr !== 32'h8000_1000) begin n_fail++; $display("FAIL byp_t1_paddr got %0h want 80001000", o_paddr); end
      n_tests++; if (o_suc !== 1'b1) begin n_fail++; $display("FAIL byp_t1_suc got %0b want 1", o_suc); end
      n_tests++; if ({o_addr, o_op, o_flag} !== {32'h1000, 32'hA5, 1'b1}) begin n_fail++; $display("FAIL byp_t1_early got %0h/%0h/%0b want 1000/a5/1", o_addr, o_op, o_flag); end
      n_tests++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL byp_t1_count got %0d want 1", o_count); end
      tick();
      drive_idle();
      sample();
      n_tests++; if ({o_valid, o_count} !== 4'b0000) begin n_fail++; $display("FAIL byp_t2_empty got valid=%0b count=%0d want 0/0", o_valid, o_count); end
      tick();
   endtask

   task automatic test_full();
      sel = 1'b0;
      drive_idle();
      drive_push(32'h10, 32'h1, 1'b0);
      tick();
      drive_idle();
      drive_push(32'h20, 32'h2, 1'b1);
      mmu_paddr = 32'h9000_0010;
      mmu_suc   = 1'b0;
      tick();
      drive_idle();
      drive_push(32'h30, 32'h3, 1'b0);
      mmu_paddr = 32'h9000_0020;
      mmu_suc   = 1'b1;
      sample();
      n_tests++; if (o_count !== 3'd2) begin n_fail++; $display("FAIL full_count got %0d want 2", o_count); end
      n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %0b want 0", o_ready); end
      tick();
      drive_idle();
      drive_push(32'h40, 32'h4, 1'b0);
      mmu_paddr = 32'hDEAD_BEEF;
      out_ready = 1'b1;
      sample();
      n_tests++; if (o_count !== 3'd2) begin n_fail++; $display("FAIL full_hold_count got %0d want 2", o_count); end
      n_tests++; if ({o_valid, o_addr, o_paddr, o_suc} !== {1'b1, 32'h10, 32'h9000_0010, 1'b0}) begin n_fail++; $display("FAIL full_first got v=%0b %0h %0h %0b want 1 10 90000010 0", o_valid, o_addr, o_paddr, o_suc); end
      tick();
      drive_idle();
      out_ready = 1'b1;
      sample();
      n_tests++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL full_pop_count got %0d want 1", o_count); end
      n_tests++; if ({o_valid, o_addr, o_paddr, o_suc} !== {1'b1, 32'h20, 32'h9000_0020, 1'b1}) begin n_fail++; $display("FAIL full_second got v=%0b %0h %0h %0b want 1 20 90000020 1", o_valid, o_addr, o_paddr, o_suc); end
      tick();
      drive_idle();
      sample();
      n_tests++; if ({o_valid, o_count} !== 4'b0000) begin n_fail++; $display("FAIL full_drained got valid=%0b count=%0d want 0/0", o_valid, o_count); end
      tick();
   endtask

   task automatic test_lat3();
      sel = 1'b1;
      drive_idle();
      drive_push(32'h2000, 32'h7, 1'b0);
      for (int t = 0; t < 3; t++) begin
         sample();
         n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL lat3_early_valid t=%0d got %0b want 0", t, o_valid); end
         tick();
         drive_idle();
      end
      mmu_paddr = 32'h8000_2000;
      mmu_suc   = 1'b0;
      sample();
      n_tests++; if ({o_valid, o_paddr, o_suc} !== {1'b1, 32'h8000_2000, 1'b0}) begin n_fail++; $display("FAIL lat3_bypass got v=%0b %0h %0b want 1 80002000 0", o_valid, o_paddr, o_suc); end
      tick();
      drive_idle();
      mmu_paddr = 32'h7FFF_DFFF;
      mmu_suc   = 1'b1;
      out_ready = 1'b1;
      sample();
      n_tests++; if ({o_valid, o_addr, o_paddr, o_suc} !== {1'b1, 32'h2000, 32'h8000_2000, 1'b0}) begin n_fail++; $display("FAIL lat3_stored got v=%0b %0h %0h %0b want 1 2000 80002000 0", o_valid, o_addr, o_paddr, o_suc); end
      tick();
      drive_idle();
      sample();
      n_tests++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL lat3_drained got %0d want 0", o_count); end
      tick();
   endtask

   task automatic test_flush();
      sel = 1'b0;
      drive_idle();
      drive_push(32'h100, 32'h11, 1'b0);
      tick();
      drive_idle();
      drive_push(32'h200, 32'h22, 1'b0);
      mmu_paddr = 32'h111;
      tick();
      drive_idle();
      drive_push(32'h300, 32'h33, 1'b0);
      flush     = 1'b1;
      mmu_paddr = 32'h222;
      sample();
      n_tests++; if (o_count !== 3'd2) begin n_fail++; $display("FAIL flush_pre_count got %0d want 2", o_count); end
      tick();
      drive_idle();
      drive_push(32'h400, 32'h44, 1'b1);
      sample();
      n_tests++; if ({o_valid, o_ready, o_count} !== 5'b01000) begin n_fail++; $display("FAIL flush_post got v=%0b rdy=%0b cnt=%0d want 0 1 0", o_valid, o_ready, o_count); end
      tick();
      drive_idle();
      mmu_paddr = 32'h8000_0400;
      mmu_suc   = 1'b1;
      out_ready = 1'b1;
      sample();
      n_tests++; if ({o_valid, o_addr, o_op, o_paddr, o_suc} !== {1'b1, 32'h400, 32'h44, 32'h8000_0400, 1'b1}) begin n_fail++; $display("FAIL flush_next got v=%0b %0h %0h %0h %0b want 1 400 44 80000400 1", o_valid, o_addr, o_op, o_paddr, o_suc); end
      n_tests++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL flush_next_count got %0d want 1", o_count); end
      tick();
      drive_idle();
      sample();
      n_tests++; if ({o_valid, o_count} !== 4'b0000) begin n_fail++; $display("FAIL flush_drained got v=%0b cnt=%0d want 0/0", o_valid, o_count); end
      tick();
   endtask

   // Random traffic; model: in-order queue, each entry's late data due lat cycles after its push.
   task automatic test_stream(input logic s, input int ncyc);
      int          dep;
      int          lat;
      int          n_push;
      int          sz;
      logic        exp_v;
      logic        do_push;
      logic [31:0] nxt_paddr;
      logic        nxt_suc;
      sel = s;
      dep = s ? 4 : 2;
      lat = s ? 3 : 1;
      n_push = 0;
      exp_q.delete();
      cyc_q.delete();
      drive_idle();
      flush = 1'b1;
      tick();
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         drive_idle();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 29) == 0);
         nxt_paddr = $urandom;
         nxt_suc   = 1'($urandom_range(0, 1));
         foreach (cyc_q[i]) begin
            if (cyc_q[i] + lat == cyc) begin
               mmu_paddr = exp_q[i][32:1];
               mmu_suc   = exp_q[i][0];
            end
         end
         sz    = exp_q.size();
         exp_v = (sz > 0) && (cyc >= cyc_q[0] + lat);
         sample();
         n_tests++; if (o_count !== 3'(sz)) begin n_fail++; $display("FAIL stream_count s=%0b cyc=%0d got %0d want %0d", s, cyc, o_count, sz); end
         n_tests++; if (o_ready !== (sz < dep)) begin n_fail++; $display("FAIL stream_in_ready s=%0b cyc=%0d got %0b want %0b", s, cyc, o_ready, sz < dep); end
         n_tests++; if (o_valid !== exp_v) begin n_fail++; $display("FAIL stream_valid s=%0b cyc=%0d got %0b want %0b", s, cyc, o_valid, exp_v); end
         if (exp_v) begin
            n_tests++;
            if ({o_addr, o_op, o_flag, o_paddr, o_suc} !== exp_q[0]) begin
               n_fail++;
               $display("FAIL stream_head s=%0b cyc=%0d got %0h want %0h", s, cyc, {o_addr, o_op, o_flag, o_paddr, o_suc}, exp_q[0]);
            end
         end
         do_push = in_valid && (sz < dep);
         if (flush) begin
            exp_q.delete();
            cyc_q.delete();
         end else begin
            if (exp_v && out_ready) begin
               void'(exp_q.pop_front());
               void'(cyc_q.pop_front());
            end
            if (do_push) begin
               exp_q.push_back({in_addr, in_opcode, in_opflag, nxt_paddr, nxt_suc});
               cyc_q.push_back(cyc);
               n_push++;
            end
         end
         tick();
      end
      n_tests++; if (n_push < 9) begin n_fail++; $display("FAIL stream_pushes s=%0b got %0d want >=9", s, n_push); end
      drive_idle();
      flush = 1'b1;
      tick();
      drive_idle();
   endtask

   task automatic test_reset_busy();
      sel = 1'b0;
      drive_idle();
      drive_push(32'h500, 32'h55, 1'b1);
      tick();
      drive_idle();
      drive_push(32'h600, 32'h66, 1'b1);
      mmu_paddr = 32'h8000_0500;
      tick();
      drive_idle();
      rstn = 1'b0;
      sample();
      tick();
      rstn = 1'b1;
      drive_idle();
      mmu_paddr = 32'hFFFF_FFFF;
      mmu_suc   = 1'b1;
      sample();
      n_tests++; if ({o_valid, o_ready, o_count} !== 5'b01000) begin n_fail++; $display("FAIL rbusy_status got v=%0b rdy=%0b cnt=%0d want 0 1 0", o_valid, o_ready, o_count); end
      n_tests++; if ({o_addr, o_op, o_flag, o_paddr, o_suc} !== 98'd0) begin n_fail++; $display("FAIL rbusy_data got %0h/%0h/%0b/%0h/%0b want 0", o_addr, o_op, o_flag, o_paddr, o_suc); end
      tick();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      sel = 1'b0;
      rstn = 1'b0;
      drive_idle();
      test_reset();
      test_bypass();
      test_full();
      test_lat3();
      test_flush();
      test_stream(1'b1, 120);
      test_stream(1'b0, 80);
      test_reset_busy();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
